rot_sched: RTL

//  Run sequencer for the rotate engine. Latches the job configuration and checks it

---
 rtl/rot_sched_if.sv | 44 ++++
 rtl/rot_sched.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rot_sched_if.sv
// Bus bundle between the register interface and the rotate-engine run sequencer.
// The master side is the register block and core_set. The slave side is rot_sched.
interface rot_sched_if #(
  parameter int SET_W = 25
);
  // register-side controls and core_set feedback
  logic             I_RS_CFG_WE;
  logic [15:0]      I_RS_CFG_HEIGHT;
  logic [15:0]      I_RS_CFG_WIDTH;
  logic [1:0]       I_RS_CFG_DEGREES;
  logic             I_RS_CFG_DIRECTION;
  logic             I_RS_GO;
  logic             I_RS_ABORT;
  logic             I_RS_IRQ_CLR;
  logic             I_RS_CS_WRITE;
  // sequencer outputs
  logic [15:0]      O_RS_CS_HEIGHT;
  logic [15:0]      O_RS_CS_WIDTH;
  logic [1:0]       O_RS_CS_DEGREES;
  logic             O_RS_CS_DIRECTION;
  logic             O_RS_CS_START;
  logic             O_RS_CS_HRESET_N;
  logic             O_RS_BUSY;
  logic             O_RS_DONE;
  logic             O_RS_ERR;
  logic             O_RS_IRQ;
  logic [SET_W-1:0] O_RS_SET_CNT;

  modport master (
    output I_RS_CFG_WE, I_RS_CFG_HEIGHT, I_RS_CFG_WIDTH, I_RS_CFG_DEGREES,
           I_RS_CFG_DIRECTION, I_RS_GO, I_RS_ABORT, I_RS_IRQ_CLR, I_RS_CS_WRITE,
    input  O_RS_CS_HEIGHT, O_RS_CS_WIDTH, O_RS_CS_DEGREES, O_RS_CS_DIRECTION,
           O_RS_CS_START, O_RS_CS_HRESET_N, O_RS_BUSY, O_RS_DONE, O_RS_ERR,
           O_RS_IRQ, O_RS_SET_CNT
  );

  modport slave (
    input  I_RS_CFG_WE, I_RS_CFG_HEIGHT, I_RS_CFG_WIDTH, I_RS_CFG_DEGREES,
           I_RS_CFG_DIRECTION, I_RS_GO, I_RS_ABORT, I_RS_IRQ_CLR, I_RS_CS_WRITE,
    output O_RS_CS_HEIGHT, O_RS_CS_WIDTH, O_RS_CS_DEGREES, O_RS_CS_DIRECTION,
           O_RS_CS_START, O_RS_CS_HRESET_N, O_RS_BUSY, O_RS_DONE, O_RS_ERR,
           O_RS_IRQ, O_RS_SET_CNT
  );
endinterface

// File: rtl/rot_sched.sv
// rot_sched: run sequencer for the rotate engine.
// It latches the job configuration and validates it against the engine limits.
// It launches core_set, counts completed 8x8 pixel sets and reports done or error
// status with a sticky interrupt. It owns core_set's reset, so an abort flushes the core.
// Optional build macro RS_TIMEOUT_EN adds a watchdog. The watchdog ends a RUN with
// an error after TIMEOUT_CYC cycles without a completed set.
module rot_sched #(
  parameter int SET_W = 25
`ifdef RS_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  logic       I_RS_HCLK,
  input  logic       I_RS_HRESET,
  rot_sched_if.slave rs
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;

  logic [15:0]      cfg_h_r;
  logic [15:0]      cfg_w_r;
  logic [1:0]       cfg_deg_r;
  logic             cfg_dir_r;
  logic [SET_W-1:0] total_r;
  logic [SET_W-1:0] set_cnt_r;
  logic             write_q_r;
  logic             busy_r;
  logic             done_r;
  logic             err_r;
  logic             irq_r;
  logic             cs_start_r;
  logic             cs_hreset_n_r;

  logic             go_take_s;
  logic             run_entry_s;
  logic             inc_s;
  logic             done_set_s;
  logic             err_set_s;
  logic             fall_s;
  logic             illegal_s;
  logic [SET_W-1:0] cnt_next_s;
  logic [SET_W-1:0] total_s;

  // Number of 8-pixel groups along one axis: floor(x/8) plus one for any remainder.
  function automatic logic [SET_W-1:0] ceil8(input logic [15:0] x);
    logic [SET_W-1:0] q;
    q = SET_W'(x[15:3]);
    return q + SET_W'(|x[2:0]);
  endfunction

  assign fall_s     = write_q_r & ~rs.I_RS_CS_WRITE;
  assign illegal_s  = (cfg_h_r == 16'd0) || (cfg_w_r == 16'd0) ||
                      cfg_h_r[15] || (cfg_w_r[15:14] != 2'b00);
  assign cnt_next_s = set_cnt_r + SET_W'(1);
  assign total_s    = ceil8(cfg_h_r) * ceil8(cfg_w_r);

`ifdef RS_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_r;
  logic            wd_hit_s;

  assign wd_hit_s = (wd_r == WD_W'(TIMEOUT_CYC - 1));

  // Watchdog: restarts on RUN entry and on every completed set, and counts RUN cycles.
  always_ff @(posedge I_RS_HCLK) begin
    if (I_RS_HRESET) begin
      wd_r <= '0;
    end else if (run_entry_s || inc_s) begin
      wd_r <= '0;
    end else if (state_r == ST_RUN) begin
      wd_r <= wd_r + WD_W'(1);
    end else begin
      wd_r <= wd_r;
    end
  end
`endif

  // Next state plus one-cycle event strobes. ABORT has priority over everything in a job.
  always_comb begin
    state_s     = state_r;
    go_take_s   = 1'b0;
    run_entry_s = 1'b0;
    inc_s       = 1'b0;
    done_set_s  = 1'b0;
    err_set_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rs.I_RS_GO) begin
          state_s   = ST_CHECK;
          go_take_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (rs.I_RS_ABORT) begin
          state_s = ST_IDLE;
        end else if (illegal_s) begin
          state_s   = ST_IDLE;
          err_set_s = 1'b1;
        end else begin
          state_s     = ST_RUN;
          run_entry_s = 1'b1;
        end
      end
      ST_RUN: begin
        if (rs.I_RS_ABORT) begin
          state_s = ST_IDLE;
        end else if (fall_s) begin
          inc_s = 1'b1;
          if (cnt_next_s == total_r) begin
            state_s    = ST_IDLE;
            done_set_s = 1'b1;
          end else begin
            state_s = ST_RUN;
          end
        end
`ifdef RS_TIMEOUT_EN
        else if (wd_hit_s) begin
          state_s   = ST_IDLE;
          err_set_s = 1'b1;
        end
`endif
        else begin
          state_s = ST_RUN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register and the control outputs decoded from the upcoming state.
  always_ff @(posedge I_RS_HCLK) begin
    if (I_RS_HRESET) begin
      state_r       <= ST_IDLE;
      busy_r        <= 1'b0;
      cs_start_r    <= 1'b0;
      cs_hreset_n_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      busy_r        <= (state_s != ST_IDLE);
      cs_start_r    <= run_entry_s;
      cs_hreset_n_r <= (state_s == ST_RUN);
    end
  end

  // Job configuration. It can only change between jobs, so core_set sees stable values.
  always_ff @(posedge I_RS_HCLK) begin
    if (I_RS_HRESET) begin
      cfg_h_r   <= 16'd0;
      cfg_w_r   <= 16'd0;
      cfg_deg_r <= 2'd0;
      cfg_dir_r <= 1'b0;
    end else if (rs.I_RS_CFG_WE && (state_r == ST_IDLE)) begin
      cfg_h_r   <= rs.I_RS_CFG_HEIGHT;
      cfg_w_r   <= rs.I_RS_CFG_WIDTH;
      cfg_deg_r <= rs.I_RS_CFG_DEGREES;
      cfg_dir_r <= rs.I_RS_CFG_DIRECTION;
    end else begin
      cfg_h_r   <= cfg_h_r;
      cfg_w_r   <= cfg_w_r;
      cfg_deg_r <= cfg_deg_r;
      cfg_dir_r <= cfg_dir_r;
    end
  end

  // Set accounting: a delayed WRITE copy for edge detection, the job size and the count.
  always_ff @(posedge I_RS_HCLK) begin
    if (I_RS_HRESET) begin
      write_q_r <= 1'b0;
      total_r   <= '0;
      set_cnt_r <= '0;
    end else begin
      write_q_r <= rs.I_RS_CS_WRITE;
      total_r   <= run_entry_s ? total_s : total_r;
      if (go_take_s) begin
        set_cnt_r <= '0;
      end else if (inc_s) begin
        set_cnt_r <= cnt_next_s;
      end else begin
        set_cnt_r <= set_cnt_r;
      end
    end
  end

  // Sticky status and interrupt. A same-cycle set wins over IRQ_CLR.
  always_ff @(posedge I_RS_HCLK) begin
    if (I_RS_HRESET) begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      irq_r  <= 1'b0;
    end else begin
      done_r <= go_take_s ? 1'b0 : (done_r | done_set_s);
      err_r  <= go_take_s ? 1'b0 : (err_r | err_set_s);
      if (done_set_s || err_set_s) begin
        irq_r <= 1'b1;
      end else if (rs.I_RS_IRQ_CLR) begin
        irq_r <= 1'b0;
      end else begin
        irq_r <= irq_r;
      end
    end
  end

  assign rs.O_RS_CS_HEIGHT    = cfg_h_r;
  assign rs.O_RS_CS_WIDTH     = cfg_w_r;
  assign rs.O_RS_CS_DEGREES   = cfg_deg_r;
  assign rs.O_RS_CS_DIRECTION = cfg_dir_r;
  assign rs.O_RS_CS_START     = cs_start_r;
  assign rs.O_RS_CS_HRESET_N  = cs_hreset_n_r;
  assign rs.O_RS_BUSY         = busy_r;
  assign rs.O_RS_DONE         = done_r;
  assign rs.O_RS_ERR          = err_r;
  assign rs.O_RS_IRQ          = irq_r;
  assign rs.O_RS_SET_CNT      = set_cnt_r;

endmodule
